fifo_port_scheduler: RTL and testbench

Single-clock scheduler that sits in front of the 16x8 synchronous FIFO and shares its one write port among `NUM_WR` producers and its read port with one consumer. The FIFO does nothing in a cycle where both `we` and `re` are asserted. This block therefore never issues both in the same cycle. It picks producers round-robin and resolves read/write conflicts with an alternating turn bit. Producers and consumer see a simple req/ack handshake; the FIFO sees legal `we`/`re` pulses only.

---
 rtl/fifo_port_scheduler.sv | 135 +++++++++++++
 tb/tb_fifo_port_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_port_scheduler
//  Purpose  : Shares the single write port of a 16x8 synchronous FIFO among
//             NUM_WR producers (round-robin) and its read port with one
//             consumer. It never issues we and re together; read/write
//             conflicts are settled by an alternating turn bit.
//  Options  : FIFO_SCHED_RD_PRIO_EN -- when defined, a read always wins a
//             conflict and the turn bit stays at 0.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_port_scheduler #(
  parameter int NUM_WR     = 4,
  parameter int FIFO_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [NUM_WR*FIFO_WIDTH-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_ack,
  input  logic                         rd_req,
  output logic                         rd_ack,
  output logic                         rd_valid,
  output logic [FIFO_WIDTH-1:0]        rd_data,
  output logic                         fifo_we,
  output logic                         fifo_re,
  output logic [FIFO_WIDTH-1:0]        fifo_din,
  input  logic                         fifo_full,
  input  logic                         fifo_empty,
  input  logic [FIFO_WIDTH-1:0]        fifo_dout
);

  localparam int               PTR_W    = $clog2(NUM_WR);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_WR - 1);
  localparam logic [PTR_W:0]   NUM_WR_X = (PTR_W + 1)'(NUM_WR);

  // Registered state
  logic [PTR_W-1:0] rr_ptr;
  logic             turn;
  logic             rd_valid_q;

  // Decision signals
  logic             wr_elig;
  logic             rd_elig;
  logic             conflict;
  logic             do_write;
  logic             do_read;
  logic             grant_found;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] rr_next;

  // Eligibility; reset masks every request so all issue outputs stay low
  always_comb begin
    wr_elig  = (|wr_req) && !fifo_full  && !rst;
    rd_elig  = rd_req    && !fifo_empty && !rst;
    conflict = wr_elig && rd_elig;
  end

  // Round-robin scan starting at rr_ptr; first requester found wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= NUM_WR_X) begin
        cand = cand - NUM_WR_X;
      end
      if (!grant_found && wr_req[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Conflict resolution: only one of write/read is issued per cycle
  always_comb begin
`ifdef FIFO_SCHED_RD_PRIO_EN
    do_write = wr_elig && !rd_elig;
`else
    do_write = wr_elig && (!rd_elig || !turn);
`endif
    do_read  = rd_elig && !do_write;
  end

  // Pointer advances to the slot after the granted producer, with wrap
  always_comb begin
    rr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  end

  // Write-side outputs: one-hot ack and the granted producer's data
  always_comb begin
    wr_ack   = '0;
    fifo_din = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (do_write && (grant_idx == PTR_W'(k))) begin
        wr_ack[k] = 1'b1;
        fifo_din  = wr_data[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // Issue strobes and read return path
  always_comb begin
    fifo_we  = do_write;
    fifo_re  = do_read;
    rd_ack   = do_read;
    rd_valid = rd_valid_q;
    rd_data  = rd_valid_q ? fifo_dout : '0;
  end

  // State update: pointer on writes, turn on conflicts, read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      turn       <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_read;
      if (do_write) begin
        rr_ptr <= rr_next;
      end
`ifdef FIFO_SCHED_RD_PRIO_EN
      turn <= 1'b0;
`else
      if (conflict) begin
        turn <= ~turn;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_port_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_port_scheduler
//  Purpose  : Directed self-checking bench for fifo_port_scheduler with a
//             behavioural 16x8 synchronous FIFO attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_port_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_ack;
  logic        rd_req;
  logic        rd_ack;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        fifo_we;
  logic        fifo_re;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;

  int checks   = 0;
  int failures = 0;
  logic both_seen = 1'b0;

  fifo_port_scheduler #(
    .NUM_WR     (4),
    .FIFO_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_we    (fifo_we),
    .fifo_re    (fifo_re),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 16x8 FIFO: does nothing when we and re are both high
  logic [7:0] mem [16];
  logic [4:0] cnt;
  logic [3:0] wp;
  logic [3:0] rp;
  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wp        <= '0;
      rp        <= '0;
      fifo_dout <= '0;
    end else if (fifo_we && !fifo_re && !fifo_full) begin
      mem[wp] <= fifo_din;
      wp      <= wp + 4'd1;
      cnt     <= cnt + 5'd1;
    end else if (fifo_re && !fifo_we && !fifo_empty) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 4'd1;
      cnt       <= cnt - 5'd1;
    end
  end

  // Sticky monitor for simultaneous we/re, sampled mid-cycle
  always begin
    @(negedge clk);
    #4;
    if (fifo_we && fifo_re) both_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    wr_data = {d3, d2, d1, d0};
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  logic [7:0] exp_q[$];
  logic [6:0] pattern;
  logic       prev_read;
  logic [7:0] exp_byte;

  initial begin
    // ---------------- reset with all requests high ----------------
    rst = 1'b1; wr_req = 4'hF; rd_req = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    repeat (2) @(posedge clk);
    next_cycle();
    check("rst_we",       fifo_we,  0);
    check("rst_re",       fifo_re,  0);
    check("rst_wr_ack",   wr_ack,   0);
    check("rst_rd_ack",   rd_ack,   0);
    check("rst_rd_valid", rd_valid, 0);

    // ---------------- round-robin 0,1,2,3,0 ----------------
    rst = 1'b0; rd_req = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("rr_ack", wr_ack,   32'(4'b0001 << (i % 4)));
      check("rr_din", fifo_din, 32'(8'h10 + (i % 4)));
      check("rr_we",  fifo_we,  1);
      next_cycle();
    end

    // ---------------- fill to 16, then producer 2 alone ----------------
    repeat (11) next_cycle();
    wr_req = 4'b0100;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("full_no_ack", wr_ack,  0);
      check("full_no_we",  fifo_we, 0);
      next_cycle();
    end
    rd_req = 1'b1;
    #1;
    check("full_rd_ack", rd_ack,  1);
    check("full_rd_we",  fifo_we, 0);
    next_cycle();
    rd_req = 1'b0;
    #1;
    check("full_then_ack2", wr_ack,   32'h4);
    check("full_then_din",  fifo_din, 32'h12);
    check("full_rd_valid",  rd_valid, 1);
    check("full_rd_data",   rd_data,  32'h10);
    next_cycle();
    wr_req = 4'b0000;

    // ---------------- empty: read waits for a write ----------------
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; rd_req = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("empty_no_ack",  rd_ack,  0);
      check("empty_no_re",   fifo_re, 0);
      check("empty_rd_data", rd_data, 0);
      next_cycle();
    end
    set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    wr_req = 4'b0001;
    #1;
    check("empty_wr_ack",  wr_ack,   1);
    check("empty_wr_din",  fifo_din, 32'hA5);
    check("empty_wr_noRd", rd_ack,   0);
    next_cycle();
    wr_req = 4'b0000;
    #1;
    check("empty_rd_ack", rd_ack,  1);
    check("empty_re",     fifo_re, 1);
    next_cycle();
    rd_req = 1'b0;
    #1;
    check("empty_rd_valid", rd_valid, 1);
    check("empty_rd_data",  rd_data,  32'hA5);
    next_cycle();
    check("rd_valid_one_cycle", rd_valid, 0);

    // ---------------- conflict: 4 entries, rd and producer 0 ----------------
    for (int k = 0; k < 4; k++) begin
      set_data(8'h20 + 8'(k), 8'h00, 8'h00, 8'h00);
      wr_req = 4'b0001;
      exp_q.push_back(8'h20 + 8'(k));
      next_cycle();
    end
    set_data(8'h30, 8'h00, 8'h00, 8'h00);
    wr_req = 4'b0001; rd_req = 1'b1;
    #1;
`ifdef FIFO_SCHED_RD_PRIO_EN
    pattern = 7'b1010000;
`else
    pattern = 7'b1010101;
`endif
    prev_read = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("conf_we", fifo_we, 32'(pattern[i]));
      check("conf_re", fifo_re, 32'(!pattern[i]));
      if (prev_read) begin
        check("conf_rd_valid", rd_valid, 1);
        check("conf_rd_data",  rd_data,  32'(exp_byte));
      end else begin
        check("conf_rd_idle", rd_valid, 0);
      end
      if (pattern[i]) begin
        exp_q.push_back(8'h30);
        prev_read = 1'b0;
      end else begin
        exp_byte  = exp_q.pop_front();
        prev_read = 1'b1;
      end
      next_cycle();
    end
    wr_req = 4'b0000; rd_req = 1'b0;
    #1;
    check("conf_last_valid", rd_valid, 32'(prev_read));

    // ---------------- reset in the cycle of a read ----------------
    rd_req = 1'b1;
    #1;
    check("mid_rd_ack_pre", rd_ack, 1);
    rst = 1'b1;
    #1;
    check("mid_rd_ack_rst", rd_ack,  0);
    check("mid_re_rst",     fifo_re, 0);
    next_cycle();
    rst = 1'b0; rd_req = 1'b0;
    #1;
    check("mid_rd_valid", rd_valid, 0);
    set_data(8'h40, 8'h41, 8'h42, 8'h43);
    wr_req = 4'hF;
    #1;
    check("post_rst_ptr", wr_ack, 1);
    next_cycle();
    wr_req = 4'b0010; rd_req = 1'b1;
    #1;
`ifdef FIFO_SCHED_RD_PRIO_EN
    check("post_rst_turn_w", wr_ack, 0);
    check("post_rst_turn_r", rd_ack, 1);
`else
    check("post_rst_turn_w", wr_ack, 32'h2);
    check("post_rst_turn_r", rd_ack, 0);
`endif
    next_cycle();
    wr_req = 4'b0000; rd_req = 1'b0;
    next_cycle();

    check("never_we_and_re", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
